// File: rtl/dtim_arbiter.sv
// dtim_arbiter: shares the single-port DTIM RAM between the LSU (primary) and a DMA/bus port.
//
// Ports:
//   clk, reset_n                  clock, asynchronous active-low reset
//   FlushW                        suppresses a same-cycle LSU write
//   LSUReq/Write/Adr/WriteData/ByteMask   LSU request
//   LSUStall, LSUReadValid, LSUReadData   LSU status and read return
//   DmaReq/Write/Adr/WriteData/ByteMask   DMA request (held until DmaGnt)
//   DmaGnt, DmaRspValid, DmaReadData      DMA grant and read return
//   RamCe/We/Bwe/Adr/Din, RamDout         single-port RAM interface (1-cycle read latency)
module dtim_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 10,
  parameter int unsigned DATA_WIDTH   = 64,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    FlushW,
  input  logic                    LSUReq,
  input  logic                    LSUWrite,
  input  logic [ADDR_WIDTH-1:0]   LSUAdr,
  input  logic [DATA_WIDTH-1:0]   LSUWriteData,
  input  logic [DATA_WIDTH/8-1:0] LSUByteMask,
  output logic                    LSUStall,
  output logic                    LSUReadValid,
  output logic [DATA_WIDTH-1:0]   LSUReadData,
  input  logic                    DmaReq,
  input  logic                    DmaWrite,
  input  logic [ADDR_WIDTH-1:0]   DmaAdr,
  input  logic [DATA_WIDTH-1:0]   DmaWriteData,
  input  logic [DATA_WIDTH/8-1:0] DmaByteMask,
  output logic                    DmaGnt,
  output logic                    DmaRspValid,
  output logic [DATA_WIDTH-1:0]   DmaReadData,
  output logic                    RamCe,
  output logic                    RamWe,
  output logic [DATA_WIDTH/8-1:0] RamBwe,
  output logic [ADDR_WIDTH-1:0]   RamAdr,
  output logic [DATA_WIDTH-1:0]   RamDin,
  input  logic [DATA_WIDTH-1:0]   RamDout
);

  localparam int unsigned BeW  = DATA_WIDTH / 8;
  localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CntW-1:0] Limit = CntW'(STARVE_LIMIT);

  typedef enum logic [1:0] {RspNone, RspLsu, RspDma} rsp_e;

  rsp_e                  rsp_q, rsp_d;
  logic [CntW-1:0]       wait_q, wait_d;
  logic [DATA_WIDTH-1:0] lsu_hold_q, lsu_hold_d;
  logic [DATA_WIDTH-1:0] dma_hold_q, dma_hold_d;

  logic force_dma;
  logic gnt_lsu;
  logic lsu_we;

  // Grant: LSU wins unless the DMA port has been refused STARVE_LIMIT cycles in a row.
  always_comb begin
    force_dma = DmaReq & (wait_q == Limit);
    gnt_lsu   = LSUReq & ~force_dma;
    DmaGnt    = DmaReq & ~gnt_lsu;
    LSUStall  = LSUReq & ~gnt_lsu;
    // A flushed LSU write still occupies the RAM slot but must not modify memory.
    lsu_we    = LSUWrite & ~FlushW;
  end

  always_comb begin
    RamCe  = gnt_lsu | DmaGnt;
    RamWe  = 1'b0;
    RamBwe = '0;
    RamAdr = LSUAdr;
    RamDin = LSUWriteData;
    if (DmaGnt) begin
      RamAdr = DmaAdr;
      RamDin = DmaWriteData;
      RamWe  = DmaWrite;
      RamBwe = DmaWrite ? DmaByteMask : {BeW{1'b0}};
    end else if (gnt_lsu) begin
      RamWe  = lsu_we;
      RamBwe = lsu_we ? LSUByteMask : {BeW{1'b0}};
    end
  end

  // Starvation counter and response owner.
  always_comb begin
    wait_d = '0;
    if (DmaReq && !DmaGnt) begin
      wait_d = (wait_q == Limit) ? wait_q : wait_q + CntW'(1);
    end

    rsp_d = RspNone;
    if (gnt_lsu && !LSUWrite) begin
      rsp_d = RspLsu;
    end else if (DmaGnt && !DmaWrite) begin
      rsp_d = RspDma;
    end

    lsu_hold_d = (rsp_q == RspLsu) ? RamDout : lsu_hold_q;
    dma_hold_d = (rsp_q == RspDma) ? RamDout : dma_hold_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_q      <= RspNone;
      wait_q     <= '0;
      lsu_hold_q <= '0;
      dma_hold_q <= '0;
    end else begin
      rsp_q      <= rsp_d;
      wait_q     <= wait_d;
      lsu_hold_q <= lsu_hold_d;
      dma_hold_q <= dma_hold_d;
    end
  end

  // Read data bypasses the hold register in the return cycle.
  always_comb begin
    LSUReadValid = (rsp_q == RspLsu);
    DmaRspValid  = (rsp_q == RspDma);
    LSUReadData  = LSUReadValid ? RamDout : lsu_hold_q;
    DmaReadData  = DmaRspValid ? RamDout : dma_hold_q;
  end

endmodule

// File: tb/tb_dtim_arbiter.sv
// tb_dtim_arbiter: directed and randomized bench for dtim_arbiter with a behavioural RAM and
// a cycle-level reference model (grant rule, scoreboard memory, pending response).
module tb_dtim_arbiter;

  localparam int AW  = 10;
  localparam int DW  = 64;
  localparam int BW  = DW / 8;
  localparam int LIM = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          FlushW;
  logic          LSUReq, LSUWrite;
  logic [AW-1:0] LSUAdr;
  logic [DW-1:0] LSUWriteData;
  logic [BW-1:0] LSUByteMask;
  logic          LSUStall, LSUReadValid;
  logic [DW-1:0] LSUReadData;
  logic          DmaReq, DmaWrite;
  logic [AW-1:0] DmaAdr;
  logic [DW-1:0] DmaWriteData;
  logic [BW-1:0] DmaByteMask;
  logic          DmaGnt, DmaRspValid;
  logic [DW-1:0] DmaReadData;
  logic          RamCe, RamWe;
  logic [BW-1:0] RamBwe;
  logic [AW-1:0] RamAdr;
  logic [DW-1:0] RamDin;
  logic [DW-1:0] RamDout = '0;

  dtim_arbiter #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .STARVE_LIMIT(LIM)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .FlushW      (FlushW),
    .LSUReq      (LSUReq),
    .LSUWrite    (LSUWrite),
    .LSUAdr      (LSUAdr),
    .LSUWriteData(LSUWriteData),
    .LSUByteMask (LSUByteMask),
    .LSUStall    (LSUStall),
    .LSUReadValid(LSUReadValid),
    .LSUReadData (LSUReadData),
    .DmaReq      (DmaReq),
    .DmaWrite    (DmaWrite),
    .DmaAdr      (DmaAdr),
    .DmaWriteData(DmaWriteData),
    .DmaByteMask (DmaByteMask),
    .DmaGnt      (DmaGnt),
    .DmaRspValid (DmaRspValid),
    .DmaReadData (DmaReadData),
    .RamCe       (RamCe),
    .RamWe       (RamWe),
    .RamBwe      (RamBwe),
    .RamAdr      (RamAdr),
    .RamDin      (RamDin),
    .RamDout     (RamDout)
  );

  always #5 clk = ~clk;

  // Behavioural single-port RAM: read data appears next cycle and holds while idle.
  logic [DW-1:0] ram_mem [2**AW];
  always @(posedge clk) begin
    if (RamCe) begin
      if (RamWe) begin
        for (int b = 0; b < BW; b++) begin
          if (RamBwe[b]) ram_mem[RamAdr][b*8 +: 8] <= RamDin[b*8 +: 8];
        end
      end else begin
        RamDout <= ram_mem[RamAdr];
      end
    end
  end

  // Reference model state.
  int            total = 0;
  int            bad   = 0;
  logic [DW-1:0] ref_mem [2**AW];
  int            refused;
  int            pend_own;   // 0 none, 1 LSU, 2 DMA
  logic [DW-1:0] pend_data;
  logic [DW-1:0] lsu_hold, dma_hold;
  logic          last_gd;
  logic          obs_gd;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    refused  = 0;
    pend_own = 0;
    lsu_hold = '0;
    dma_hold = '0;
  endtask

  task automatic apply_mask(input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [BW-1:0] m);
    for (int b = 0; b < BW; b++) begin
      if (m[b]) ref_mem[a][b*8 +: 8] = d[b*8 +: 8];
    end
  endtask

  // One clock cycle: drive, check at negedge, advance the model, return at posedge+1.
  task automatic step(input logic lr, input logic lw, input logic [AW-1:0] la,
                      input logic [DW-1:0] ld, input logic [BW-1:0] lm, input logic fl,
                      input logic dr, input logic dw, input logic [AW-1:0] da,
                      input logic [DW-1:0] dd, input logic [BW-1:0] dm);
    logic ef, egl, egd, lwe;
    LSUReq = lr; LSUWrite = lw; LSUAdr = la; LSUWriteData = ld; LSUByteMask = lm; FlushW = fl;
    DmaReq = dr; DmaWrite = dw; DmaAdr = da; DmaWriteData = dd; DmaByteMask = dm;
    @(negedge clk);
    ef  = dr && (refused == LIM);
    egl = lr && !ef;
    egd = dr && !egl;
    lwe = lw && !fl;
    obs_gd = DmaGnt;
    chk("lsu_stall", LSUStall, lr && !egl);
    chk("dma_gnt", DmaGnt, egd);
    chk("ram_ce", RamCe, egl || egd);
    if (egl) begin
      chk("ram_adr_lsu", RamAdr, la);
      chk("ram_we_lsu", RamWe, lwe);
      chk("ram_bwe_lsu", RamBwe, lwe ? lm : '0);
      if (lwe) chk("ram_din_lsu", RamDin, ld);
    end else if (egd) begin
      chk("ram_adr_dma", RamAdr, da);
      chk("ram_we_dma", RamWe, dw);
      chk("ram_bwe_dma", RamBwe, dw ? dm : '0);
      if (dw) chk("ram_din_dma", RamDin, dd);
    end
    chk("lsu_valid", LSUReadValid, pend_own == 1);
    chk("dma_valid", DmaRspValid, pend_own == 2);
    chk("lsu_data", LSUReadData, (pend_own == 1) ? pend_data : lsu_hold);
    chk("dma_data", DmaReadData, (pend_own == 2) ? pend_data : dma_hold);
    if (pend_own == 1) lsu_hold = pend_data;
    if (pend_own == 2) dma_hold = pend_data;
    pend_own = 0;
    if (egl && !lw) begin
      pend_own = 1; pend_data = ref_mem[la];
    end else if (egd && !dw) begin
      pend_own = 2; pend_data = ref_mem[da];
    end
    if (egl && lwe) apply_mask(la, ld, lm);
    if (egd && dw) apply_mask(da, dd, dm);
    refused = (dr && !egd) ? ((refused < LIM) ? refused + 1 : LIM) : 0;
    last_gd = egd;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(0, 0, '0, '0, '0, 0, 0, 0, '0, '0, '0);
  endtask

  logic          dpend;
  logic          dwr;
  logic [AW-1:0] dadr;
  logic [DW-1:0] ddat;
  logic [BW-1:0] dmsk;

  initial begin
    model_reset();
    // Reset with every request high (reads, so the RAM stays untouched).
    reset_n = 1'b0; FlushW = 1'b0;
    LSUReq = 1'b1; LSUWrite = 1'b0; LSUAdr = '0; LSUWriteData = '0; LSUByteMask = '1;
    DmaReq = 1'b1; DmaWrite = 1'b0; DmaAdr = '0; DmaWriteData = '0; DmaByteMask = '1;
    @(negedge clk);
    chk("rst_lsu_valid", LSUReadValid, 1'b0);
    chk("rst_dma_valid", DmaRspValid, 1'b0);
    chk("rst_lsu_data", LSUReadData, '0);
    chk("rst_dma_data", DmaReadData, '0);
    chk("rst_lsu_stall", LSUStall, 1'b0);
    chk("rst_dma_gnt", DmaGnt, 1'b0);
    LSUReq = 1'b0; DmaReq = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Preload the low addresses through the LSU with full masks.
    for (int a = 0; a < 16; a++) step(1, 1, AW'(a), {$urandom, $urandom}, '1, 0,
                                      0, 0, '0, '0, '0);

    // Contention: LSU wins LIM cycles, then the DMA port is forced through.
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 10'd4, '0, '0, 0, 1, 0, 10'd3, '0, '0);
      chk("contention_pattern", obs_gd, (i % (LIM + 1)) == LIM);
    end
    idle();

    // LSU write then read back; data then held through idle cycles.
    step(1, 1, 10'd5, 64'hDEADBEEF_01234567, 8'hFF, 0, 0, 0, '0, '0, '0);
    step(1, 0, 10'd5, '0, '0, 0, 0, 0, '0, '0, '0);
    chk("rd5_valid", LSUReadValid, 1'b1);
    chk("rd5_data", LSUReadData, 64'hDEADBEEF_01234567);
    idle();
    idle();
    chk("rd5_hold", LSUReadData, 64'hDEADBEEF_01234567);

    // Partial byte mask, then a flushed write that must not land.
    step(1, 1, 10'd5, '1, 8'h0F, 0, 0, 0, '0, '0, '0);
    step(1, 1, 10'd5, 64'h1111_2222_3333_4444, 8'hFF, 1, 0, 0, '0, '0, '0);
    step(1, 0, 10'd5, '0, '0, 0, 0, 0, '0, '0, '0);
    chk("mask_flush_data", LSUReadData, 64'hDEADBEEF_FFFFFFFF);

    // Interleaved owners on consecutive cycles.
    step(1, 0, 10'd1, '0, '0, 0, 0, 0, '0, '0, '0);
    step(0, 0, '0, '0, '0, 0, 1, 0, 10'd2, '0, '0);
    chk("inter_dma_valid", DmaRspValid, 1'b1);
    chk("inter_dma_data", DmaReadData, ref_mem[2]);
    chk("inter_lsu_hold", LSUReadData, ref_mem[1]);
    idle();

    // Reset arriving while a DMA read response is due.
    step(0, 0, '0, '0, '0, 0, 1, 0, 10'd6, '0, '0);
    LSUReq = 1'b0; DmaReq = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("rstmid_dma_valid", DmaRspValid, 1'b0);
    chk("rstmid_dma_data", DmaReadData, '0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    idle();

    // Randomized traffic over a small address window to hit read-after-write.
    dpend = 1'b0; dwr = 1'b0; dadr = '0; ddat = '0; dmsk = '0;
    for (int i = 0; i < 400; i++) begin
      if (!dpend && ($urandom_range(1) == 1)) begin
        dpend = 1'b1;
        dwr   = ($urandom_range(2) == 0);
        dadr  = AW'($urandom_range(15));
        ddat  = {$urandom, $urandom};
        dmsk  = BW'($urandom);
      end
      step($urandom_range(3) != 0, $urandom_range(1) == 1, AW'($urandom_range(15)),
           {$urandom, $urandom}, BW'($urandom), $urandom_range(7) == 0,
           dpend, dwr, dadr, ddat, dmsk);
      if (last_gd) dpend = 1'b0;
    end
    idle();
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dtim_arbiter.md
Name: dtim_arbiter

Overview:
- Shares the single-port data tightly-integrated memory between two requesters:
  - the LSU, which is the primary, latency-critical port;
  - a secondary bus/DMA port with a valid/grant handshake.
- Issues at most one RAM access per cycle.
- Routes the one-cycle-latency read data back to whichever requester issued the read.
- Guarantees forward progress for the DMA port through a starvation counter.
- Sits between the LSU/bus interface and the byte-enabled single-port RAM inside the DTIM.

Parameters:
- ADDR_WIDTH, 10, RAM word-address width (depth = 2^ADDR_WIDTH words).
- DATA_WIDTH, 64, RAM word width in bits (LLEN); must be a multiple of 8.
- STARVE_LIMIT, 4, consecutive refused DMA cycles before the DMA port is forced to win; range 1..15.

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset, asynchronous, active-low.
- FlushW  in  1  suppresses an LSU write issued in the same cycle.
- LSUReq  in  1  LSU access request.
- LSUWrite  in  1  1 = write, 0 = read.
- LSUAdr  in  ADDR_WIDTH  LSU word address.
- LSUWriteData  in  DATA_WIDTH  LSU write data.
- LSUByteMask  in  DATA_WIDTH/8  LSU byte write enables.
- LSUStall  out  1  LSU request not accepted this cycle.
- LSUReadValid  out  1  LSU read data valid.
- LSUReadData  out  DATA_WIDTH  LSU read data, held stable until the next LSU read returns.
- DmaReq  in  1  DMA access request; held until granted.
- DmaWrite  in  1  1 = write.
- DmaAdr  in  ADDR_WIDTH  DMA word address.
- DmaWriteData  in  DATA_WIDTH  DMA write data.
- DmaByteMask  in  DATA_WIDTH/8  DMA byte enables.
- DmaGnt  out  1  DMA request accepted this cycle.
- DmaRspValid  out  1  DMA read data valid (exactly one pulse per granted read).
- DmaReadData  out  DATA_WIDTH  DMA read data.
- RamCe  out  1  RAM chip enable.
- RamWe  out  1  RAM write enable.
- RamBwe  out  DATA_WIDTH/8  RAM byte write enables.
- RamAdr  out  ADDR_WIDTH  RAM address.
- RamDin  out  DATA_WIDTH  RAM write data.
- RamDout  in  DATA_WIDTH  RAM read data; valid the cycle after a read; held while RamCe=0.

Behaviour:
- Clocking: single clock clk; reset_n is asynchronous and active-low.
- Reset state:
  - WaitCnt = 0 and RspOwner = NONE.
  - LSU and DMA hold registers = 0.
  - Consequently LSUReadValid = 0, DmaRspValid = 0, LSUReadData = 0, DmaReadData = 0.
- Grant logic (combinational, same cycle):
  - Force = DmaReq & (WaitCnt == STARVE_LIMIT).
  - GntLsu = LSUReq & ~Force.
  - DmaGnt = DmaReq & ~GntLsu.
  - LSUStall = LSUReq & ~GntLsu.
- RAM drive:
  - RamCe = GntLsu | DmaGnt.
  - Address, write data and byte enables come from the granted port; RamWe = selected Write bit.
  - RamBwe = selected mask when writing, otherwise all zeros.
  - An LSU write with FlushW=1 drives RamWe=0 and RamBwe=0; RamCe stays 1 and the access counts as granted.
- Starvation counter (WaitCnt, width clog2(STARVE_LIMIT+1)):
  - Increments when DmaReq & ~DmaGnt.
  - Clears when DmaGnt or ~DmaReq.
  - Never exceeds STARVE_LIMIT.
- Response FSM (RspOwner ∈ {NONE, LSU, DMA}), registered every cycle:
  - next = LSU on a granted LSU read;
  - next = DMA on a granted DMA read;
  - otherwise next = NONE.
  - Writes produce no response.
- Read data outputs:
  - LSUReadValid = (RspOwner == LSU). LSUReadData = RamDout when valid, otherwise the LSU hold register.
  - The LSU hold register captures RamDout on every cycle with RspOwner == LSU.
  - The DMA side is symmetric.
  - Read latency: request cycle N → data valid in cycle N+1.
  - Back-to-back reads alternating between owners are allowed every cycle.
- Simultaneous requests: LSU wins unless Force is asserted; DMA is granted in idle LSU cycles.
- Read after write to the same address returns the new data (RAM write-first not required; the write is committed before the next-cycle read).
- Reset mid-operation: a pending response is discarded (no valid pulse) and the counter clears.

Test Plan:
- Reset:
  - Stimulus: assert reset_n=0 with all requests high.
  - Response: LSUReadValid=DmaRspValid=0, read data=0, WaitCnt=0; after release the first grant follows the normal rules.
- LSU read/write:
  - Stimulus: write 0xDEADBEEF_01234567 mask 0xFF to addr 5, then read addr 5.
  - Response: LSUStall=0 throughout; LSUReadValid in the cycle after the read; data matches; data held until the next LSU read.
- Byte mask and flush:
  - Stimulus: write 0xFF.. mask 0x0F to addr 5, then an LSU write with FlushW=1 to addr 5.
  - Response: a read of addr 5 returns 0xDEADBEEF_FFFFFFFF; the flushed write is absent.
- Contention:
  - Stimulus: LSUReq and DmaReq both held high continuously with STARVE_LIMIT=4.
  - Response: LSU granted 4 cycles, DMA granted on the 5th with LSUStall=1 that cycle; the pattern repeats.
- Interleaved reads:
  - Stimulus: LSU reads addr 1 at cycle N, DMA reads addr 2 at cycle N+1 (LSUReq low).
  - Response: LSUReadValid at N+1 with mem[1]; DmaRspValid at N+2 with mem[2]; LSUReadData still holds mem[1] at N+2.
- Reset mid-read:
  - Stimulus: grant a DMA read, then assert reset_n the next cycle.
  - Response: no DmaRspValid pulse, and RspOwner=NONE after reset.
